// File: rtl/lifo_pkg.sv
// lifo_pkg: shared definitions for the lifo_stack block.
//   - default data width and depth
//   - level/address width helpers
//   - opcodes for the decoded per-cycle request
package lifo_pkg;

    localparam int unsigned DefDataW = 8;
    localparam int unsigned DefDepth = 8;

    // Decoded request, one per clock. Flush outranks any push/pop pair.
    localparam logic [2:0] OpNop   = 3'd0;
    localparam logic [2:0] OpPush  = 3'd1;
    localparam logic [2:0] OpPop   = 3'd2;
    localparam logic [2:0] OpRepl  = 3'd3;
    localparam logic [2:0] OpFlush = 3'd4;

    // Width needed to hold 0..depth inclusive.
    function automatic int unsigned lvl_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Width needed to address entries 0..depth-1.
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/lifo_mem.sv
// lifo_mem: DEPTH x DATA_W register array, synchronous write, asynchronous read.
// Ports:
//   clk    in   write clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  read data (combinational)
// Contents are never reset.
module lifo_mem #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned AW     = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // With a non-power-of-two depth, raddr can point past the array while the
    // stack is empty; the value is unused then, so return zero.
    assign rdata = (32'(raddr) < DEPTH) ? mem_q[raddr] : '0;

endmodule

// File: rtl/lifo_stack.sv
// lifo_stack: parametrised LIFO stack controller with replace-top, flush,
// fill level, almost-full warning and overflow/underflow reporting.
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   din          in   push data
//   push/pop     in   requests, sampled every clock
//   flush        in   synchronous clear, outranks push/pop
//   dout         out  data of the last accepted pop (registered)
//   pushed       out  push accepted pulse
//   popped       out  pop accepted pulse, dout valid
//   full/empty   out  level == DEPTH / level == 0
//   almost_full  out  level >= AFULL_TH
//   level        out  stored entry count
//   ovf/udf      out  push rejected (full) / pop rejected (empty)
// Build option: LIFO_ERR_STICKY_EN makes ovf/udf sticky until rst or flush;
// otherwise they are one-cycle pulses.
module lifo_stack
    import lifo_pkg::*;
#(
    parameter int unsigned DATA_W   = DefDataW,
    parameter int unsigned DEPTH    = DefDepth,
    parameter int unsigned AFULL_TH = DEPTH - 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_W-1:0]              din,
    input  logic                           push,
    input  logic                           pop,
    input  logic                           flush,
    output logic [DATA_W-1:0]              dout,
    output logic                           pushed,
    output logic                           popped,
    output logic                           full,
    output logic                           empty,
    output logic                           almost_full,
    output logic [lvl_width(DEPTH)-1:0]    level,
    output logic                           ovf,
    output logic                           udf
);

    localparam int unsigned LVL_W = lvl_width(DEPTH);
    localparam int unsigned AW    = addr_width(DEPTH);

    localparam logic [LVL_W-1:0] LvlFull  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LvlAfull = LVL_W'(AFULL_TH);

    logic [LVL_W-1:0]  level_q, level_d;
    logic [DATA_W-1:0] dout_q;
    logic              pushed_q, popped_q, ovf_q, udf_q;

    logic [2:0]        op;
    logic              ovf_set, udf_set;

    logic              mem_we;
    logic [AW-1:0]     top_addr, mem_waddr;
    logic [DATA_W-1:0] mem_rdata;

    // Request decode
    always_comb begin
        op      = OpNop;
        ovf_set = 1'b0;
        udf_set = 1'b0;
        if (flush) begin
            op = OpFlush;
        end else if (push && pop) begin
            if (level_q != '0) begin
                op = OpRepl;
            end else begin
                // Empty: the push still goes through, the pop is rejected.
                op      = OpPush;
                udf_set = 1'b1;
            end
        end else if (push) begin
            if (level_q != LvlFull) begin
                op = OpPush;
            end else begin
                ovf_set = 1'b1;
            end
        end else if (pop) begin
            if (level_q != '0) begin
                op = OpPop;
            end else begin
                udf_set = 1'b1;
            end
        end
    end

    always_comb begin
        case (op)
            OpFlush: level_d = '0;
            OpPush:  level_d = level_q + LVL_W'(1);
            OpPop:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage addressing: a push writes one above the top, replace overwrites
    // the top in place while its old value is read out.
    assign top_addr  = AW'(level_q - LVL_W'(1));
    assign mem_waddr = (op == OpPush) ? AW'(level_q) : top_addr;
    assign mem_we    = (op == OpPush) || (op == OpRepl);

    lifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk    (clk),
        .we     (mem_we),
        .waddr  (mem_waddr),
        .wdata  (din),
        .raddr  (top_addr),
        .rdata  (mem_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q  <= '0;
            dout_q   <= '0;
            pushed_q <= 1'b0;
            popped_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            level_q  <= level_d;
            pushed_q <= (op == OpPush) || (op == OpRepl);
            popped_q <= (op == OpPop) || (op == OpRepl);
            if ((op == OpPop) || (op == OpRepl)) begin
                dout_q <= mem_rdata;
            end
`ifdef LIFO_ERR_STICKY_EN
            ovf_q <= (op == OpFlush) ? 1'b0 : (ovf_q | ovf_set);
            udf_q <= (op == OpFlush) ? 1'b0 : (udf_q | udf_set);
`else
            ovf_q <= ovf_set;
            udf_q <= udf_set;
`endif
        end
    end

    assign dout        = dout_q;
    assign pushed      = pushed_q;
    assign popped      = popped_q;
    assign ovf         = ovf_q;
    assign udf         = udf_q;
    assign level       = level_q;
    assign full        = (level_q == LvlFull);
    assign empty       = (level_q == '0);
    assign almost_full = (level_q >= LvlAfull);

endmodule
